// File: rtl/burst_engine.sv
// Burst reduction engine: deserialises DMA bursts into lane buffers, reduces them
// (CONV / MPOOL / APOOL) and serialises one result burst. Macro BURST_ENGINE_SAT_EN selects saturating output.
module burst_engine #(
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = 16,
  parameter int AVG_SHIFT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              engine_valid,
  input  logic [2:0]        op_type,
  input  logic [7:0]        op_num,
  input  logic [29:0]       data_start_addr,
  input  logic [29:0]       weight_start_addr,
  input  logic [29:0]       result_start_addr,
  output logic              engine_ready,
  output logic              dma_rd_en,
  output logic [29:0]       p2_addr,
  output logic [29:0]       p3_addr,
  input  logic              dma_p2_ob_we,
  input  logic [DATA_W-1:0] dma_p2_ob_data,
  input  logic              dma_p3_ob_we,
  input  logic [DATA_W-1:0] dma_p3_ob_data,
  output logic              dma_wr_en,
  output logic [29:0]       p0_addr,
  input  logic              dma_p0_ib_re,
  output logic [DATA_W-1:0] dma_p0_ib_data,
  output logic              dma_p0_ib_valid
);
  // state   | meaning
  // IDLE    | wait for engine_valid, latch command
  // DESER   | collect one data (and weight) burst
  // COMPUTE | update every lane accumulator
  // NEXT    | advance addresses / burst counter
  // SER     | hand result beats to the DMA
  // FINISH  | one-cycle engine_ready pulse
  localparam int ACC_W = 2*DATA_W + 8;
  localparam int IDX_W = $clog2(BURST_LEN);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] LEN       = CNT_W'(BURST_LEN);
  localparam logic [29:0]      ADDR_STEP = 30'(BURST_LEN);
  localparam logic [2:0] OP_CONV = 3'd1, OP_MPOOL = 3'd4, OP_APOOL = 3'd5;

  typedef enum logic [2:0] {IDLE, DESER, COMPUTE, NEXT, SER, FINISH} state_t;
  state_t state, state_nxt;

  logic [2:0]              op_q;
  logic [7:0]              num_q, bcnt;
  logic [CNT_W-1:0]        dcnt, wcnt, ocnt;
  logic signed [DATA_W-1:0] dbuf [BURST_LEN];
  logic signed [DATA_W-1:0] wbuf [BURST_LEN];
  logic signed [ACC_W-1:0]  acc  [BURST_LEN];
  logic signed [2*DATA_W-1:0] prod [BURST_LEN];
  logic signed [ACC_W-1:0]  sel_acc, sel_val;
  logic [DATA_W-1:0]       res_beat;
  logic                    op_ok, buf_full;

  assign op_ok    = (op_type == OP_CONV) || (op_type == OP_MPOOL) || (op_type == OP_APOOL);
  assign buf_full = (dcnt == LEN) && ((op_q != OP_CONV) || (wcnt == LEN));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    dma_rd_en    = 1'b0;
    dma_wr_en    = 1'b0;
    engine_ready = 1'b0;
    case (state)
      IDLE:    if (engine_valid) state_nxt = (op_num == 8'd0 || !op_ok) ? FINISH : DESER;
      DESER: begin
        dma_rd_en = 1'b1;
        if (buf_full) state_nxt = COMPUTE;
      end
      COMPUTE: state_nxt = NEXT;
      NEXT:    state_nxt = (bcnt + 8'd1 < num_q) ? DESER : SER;
      SER: begin
        dma_wr_en = 1'b1;
        if (ocnt == LEN) state_nxt = FINISH;
      end
      FINISH: begin
        engine_ready = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sign-extended operands keep the low 2*DATA_W bits of the product exact.
  always_comb begin
    for (int i = 0; i < BURST_LEN; i++)
      prod[i] = {{DATA_W{dbuf[i][DATA_W-1]}}, dbuf[i]} * {{DATA_W{wbuf[i][DATA_W-1]}}, wbuf[i]};
  end

  always_comb begin
    sel_acc = acc[ocnt[IDX_W-1:0]];
    sel_val = (op_q == OP_APOOL) ? (sel_acc >>> AVG_SHIFT) : sel_acc;
  end

`ifdef BURST_ENGINE_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  always_comb begin
    if (sel_val > SAT_MAX)      res_beat = SAT_MAX[DATA_W-1:0];
    else if (sel_val < SAT_MIN) res_beat = SAT_MIN[DATA_W-1:0];
    else                        res_beat = sel_val[DATA_W-1:0];
  end
`else
  logic unused_hi;
  assign res_beat  = sel_val[DATA_W-1:0];
  assign unused_hi = ^sel_val[ACC_W-1:DATA_W];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q <= '0; num_q <= '0; bcnt <= '0;
      dcnt <= '0; wcnt <= '0; ocnt <= '0;
      p0_addr <= '0; p2_addr <= '0; p3_addr <= '0;
      dma_p0_ib_data <= '0; dma_p0_ib_valid <= 1'b0;
      for (int i = 0; i < BURST_LEN; i++) begin
        dbuf[i] <= '0; wbuf[i] <= '0; acc[i] <= '0;
      end
    end else begin
      dma_p0_ib_valid <= (state == SER) && dma_p0_ib_re && (ocnt < LEN);
      case (state)
        IDLE: if (engine_valid) begin
          op_q <= op_type; num_q <= op_num; bcnt <= '0;
          p2_addr <= data_start_addr; p3_addr <= weight_start_addr; p0_addr <= result_start_addr;
          dcnt <= '0; wcnt <= '0; ocnt <= '0;
          for (int i = 0; i < BURST_LEN; i++) acc[i] <= '0;
        end
        DESER: begin
          if (dma_p2_ob_we && dcnt < LEN) begin
            dbuf[dcnt[IDX_W-1:0]] <= dma_p2_ob_data;
            dcnt <= dcnt + 1'b1;
          end
          if (op_q == OP_CONV && dma_p3_ob_we && wcnt < LEN) begin
            wbuf[wcnt[IDX_W-1:0]] <= dma_p3_ob_data;
            wcnt <= wcnt + 1'b1;
          end
        end
        COMPUTE: for (int i = 0; i < BURST_LEN; i++) begin
          case (op_q)
            OP_CONV:  acc[i] <= acc[i] + {{(ACC_W-2*DATA_W){prod[i][2*DATA_W-1]}}, prod[i]};
            OP_MPOOL: if (bcnt == 8'd0 || dbuf[i] > acc[i])
                        acc[i] <= {{(ACC_W-DATA_W){dbuf[i][DATA_W-1]}}, dbuf[i]};
            OP_APOOL: acc[i] <= acc[i] + {{(ACC_W-DATA_W){dbuf[i][DATA_W-1]}}, dbuf[i]};
            default:  acc[i] <= acc[i];
          endcase
        end
        NEXT: begin
          bcnt    <= bcnt + 8'd1;
          p2_addr <= p2_addr + ADDR_STEP;
          if (op_q == OP_CONV) p3_addr <= p3_addr + ADDR_STEP;
          dcnt <= '0; wcnt <= '0;
        end
        SER: if (dma_p0_ib_re && ocnt < LEN) begin
          dma_p0_ib_data <= res_beat;
          ocnt <= ocnt + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_burst_engine.sv
// Directed table-driven bench for burst_engine (BURST_LEN=16, DATA_W=16, AVG_SHIFT=0).
module tb_burst_engine;
  localparam logic [2:0] CONV = 3'd1, MPOOL = 3'd4, APOOL = 3'd5;

  logic clk = 1'b0;
  logic rst, engine_valid, engine_ready, dma_rd_en, dma_wr_en;
  logic [2:0] op_type;
  logic [7:0] op_num;
  logic [29:0] data_start_addr, weight_start_addr, result_start_addr;
  logic [29:0] p0_addr, p2_addr, p3_addr;
  logic dma_p2_ob_we, dma_p3_ob_we, dma_p0_ib_re, dma_p0_ib_valid;
  logic [15:0] dma_p2_ob_data, dma_p3_ob_data, dma_p0_ib_data;

  int vecs_n = 0;
  int errs = 0;

  always #5 clk = ~clk;

  burst_engine #(.DATA_W(16), .BURST_LEN(16), .AVG_SHIFT(0)) dut (
    .clk(clk), .rst(rst), .engine_valid(engine_valid), .op_type(op_type), .op_num(op_num),
    .data_start_addr(data_start_addr), .weight_start_addr(weight_start_addr),
    .result_start_addr(result_start_addr), .engine_ready(engine_ready), .dma_rd_en(dma_rd_en),
    .p2_addr(p2_addr), .p3_addr(p3_addr), .dma_p2_ob_we(dma_p2_ob_we), .dma_p2_ob_data(dma_p2_ob_data),
    .dma_p3_ob_we(dma_p3_ob_we), .dma_p3_ob_data(dma_p3_ob_data), .dma_wr_en(dma_wr_en),
    .p0_addr(p0_addr), .dma_p0_ib_re(dma_p0_ib_re), .dma_p0_ib_data(dma_p0_ib_data),
    .dma_p0_ib_valid(dma_p0_ib_valid));

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  num;
    int          d0, d1, d2;
    bit          dlane;
    int          wval;
    logic [29:0] daddr, waddr, raddr;
    int          exp_base, exp_mul;
  } vec_t;

  vec_t vecs[9];

  function automatic vec_t mk(input logic [2:0] op, input logic [7:0] num, input int d0, d1, d2,
                              input bit dlane, input int wval, input logic [29:0] da, wa, ra,
                              input int eb, em);
    vec_t v;
    v.op = op; v.num = num; v.d0 = d0; v.d1 = d1; v.d2 = d2; v.dlane = dlane; v.wval = wval;
    v.daddr = da; v.waddr = wa; v.raddr = ra; v.exp_base = eb; v.exp_mul = em;
    return v;
  endfunction

  function automatic logic [15:0] dv(input vec_t v, input int b, input int k);
    int x;
    x = (b == 0) ? v.d0 : (b == 1) ? v.d1 : v.d2;
    if (v.dlane) x = x + k + 1;
    return 16'(x);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs_n++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    engine_valid = 0; op_type = 0; op_num = 0;
    data_start_addr = 0; weight_start_addr = 0; result_start_addr = 0;
    dma_p2_ob_we = 0; dma_p2_ob_data = 0; dma_p3_ob_we = 0; dma_p3_ob_data = 0; dma_p0_ib_re = 0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, " rd_en"}, {31'b0, dma_rd_en}, 0);
    check({tag, " wr_en"}, {31'b0, dma_wr_en}, 0);
    check({tag, " ready"}, {31'b0, engine_ready}, 0);
    check({tag, " p0"}, {2'b0, p0_addr}, 0);
    check({tag, " p2"}, {2'b0, p2_addr}, 0);
    check({tag, " p3"}, {2'b0, p3_addr}, 0);
    check({tag, " ib_data"}, {16'b0, dma_p0_ib_data}, 0);
    check({tag, " ib_valid"}, {31'b0, dma_p0_ib_valid}, 0);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int rdy;
    logic [29:0] ea;
    logic [15:0] ev;
    @(negedge clk);
    engine_valid = 1; op_type = v.op; op_num = v.num;
    data_start_addr = v.daddr; weight_start_addr = v.waddr; result_start_addr = v.raddr;
    @(negedge clk);
    engine_valid = 0;
    for (int b = 0; b < int'(v.num); b++) begin
      for (int n = 0; n < 30 && !dma_rd_en; n++) @(negedge clk);
      check($sformatf("v%0d rd_en b%0d", id, b), {31'b0, dma_rd_en}, 1);
      ea = v.daddr + 30'(16 * b);
      check($sformatf("v%0d p2_addr b%0d", id, b), {2'b0, p2_addr}, {2'b0, ea});
      if (v.op == CONV) begin
        ea = v.waddr + 30'(16 * b);
        check($sformatf("v%0d p3_addr b%0d", id, b), {2'b0, p3_addr}, {2'b0, ea});
      end
      for (int k = 0; k < 16; k++) begin
        dma_p2_ob_we = 1; dma_p2_ob_data = dv(v, b, k);
        dma_p3_ob_we = 1; dma_p3_ob_data = 16'(v.wval);
        // a new command while busy must not disturb the latched one
        if (b == 0 && k < 4) begin
          engine_valid = 1; op_type = MPOOL; data_start_addr = 30'h155;
        end else engine_valid = 0;
        @(negedge clk);
      end
      dma_p2_ob_data = 16'h1234; dma_p3_ob_data = 16'h4321;
      @(negedge clk);
      dma_p2_ob_we = 0; dma_p3_ob_we = 0;
    end
    for (int n = 0; n < 30 && !dma_wr_en; n++) @(negedge clk);
    check($sformatf("v%0d wr_en", id), {31'b0, dma_wr_en}, 1);
    check($sformatf("v%0d p0_addr", id), {2'b0, p0_addr}, {2'b0, v.raddr});
    rdy = 0;
    for (int i = 0; i < 16; i++) begin
      dma_p0_ib_re = 1;
      @(negedge clk);
      dma_p0_ib_re = 0;
      ev = 16'(v.exp_base + v.exp_mul * (i + 1));
      check($sformatf("v%0d valid lane%0d", id, i), {31'b0, dma_p0_ib_valid}, 1);
      check($sformatf("v%0d data lane%0d", id, i), {16'b0, dma_p0_ib_data}, {16'b0, ev});
      @(negedge clk);
      check($sformatf("v%0d idle valid lane%0d", id, i), {31'b0, dma_p0_ib_valid}, 0);
      if (engine_ready) rdy++;
    end
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (engine_ready) rdy++;
    end
    check($sformatf("v%0d ready pulses", id), rdy, 1);
  endtask

  task automatic trivial(input logic [2:0] op, input logic [7:0] num, input int id);
    int first, rdy;
    bit dma_seen;
    first = -1; rdy = 0; dma_seen = 0;
    @(negedge clk);
    engine_valid = 1; op_type = op; op_num = num;
    @(negedge clk);
    engine_valid = 0;
    for (int c = 0; c < 8; c++) begin
      if (engine_ready && first < 0) first = c;
      if (engine_ready) rdy++;
      if (dma_rd_en || dma_wr_en) dma_seen = 1;
      @(negedge clk);
    end
    check($sformatf("t%0d ready latency ok", id), {31'b0, (first >= 0 && first < 3)}, 1);
    check($sformatf("t%0d ready pulses", id), rdy, 1);
    check($sformatf("t%0d dma activity", id), {31'b0, dma_seen}, 0);
  endtask

  initial begin
    int rdy;
    vecs[0] = mk(CONV, 2, 0, 0, 0, 1, 2, 30'h100, 30'h200, 30'h300, 0, 4);
    vecs[1] = mk(MPOOL, 3, -5, 7, 3, 0, 0, 30'h1000, 30'h0, 30'h2000, 7, 0);
    vecs[2] = mk(APOOL, 3, -5, 7, 3, 0, 0, 30'h1000, 30'h0, 30'h2000, 5, 0);
`ifdef BURST_ENGINE_SAT_EN
    vecs[3] = mk(CONV, 2, 32767, 32767, 0, 0, 32767, 30'h40, 30'h3FFFFFF0, 30'h80, 32767, 0);
    vecs[7] = mk(CONV, 2, -32768, -32768, 0, 0, 32767, 30'h500, 30'h600, 30'h700, -32768, 0);
`else
    vecs[3] = mk(CONV, 2, 32767, 32767, 0, 0, 32767, 30'h40, 30'h3FFFFFF0, 30'h80, 2, 0);
    vecs[7] = mk(CONV, 2, -32768, -32768, 0, 0, 32767, 30'h500, 30'h600, 30'h700, 0, 0);
`endif
    vecs[4] = mk(MPOOL, 2, -3, -9, 0, 0, 0, 30'h10, 30'h0, 30'h20, -3, 0);
    vecs[5] = mk(CONV, 1, 0, 0, 0, 1, -3, 30'h123, 30'h456, 30'h789, 0, -3);
    vecs[6] = mk(APOOL, 2, 100, -300, 0, 1, 0, 30'h30, 30'h0, 30'h31, -200, 2);
    vecs[8] = mk(MPOOL, 2, 10, 0, 0, 1, 0, 30'h3FFFFFF8, 30'h0, 30'h3FFFFFFF, 10, 1);

    idle_inputs();
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    check_zero_outputs("reset");

    for (int v = 0; v < 9; v++) run_vec(vecs[v], v);

    trivial(CONV, 8'd0, 0);
    trivial(3'd2, 8'd3, 1);
    trivial(3'd7, 8'd5, 2);

    // reset in the middle of a burst, then a fresh command
    @(negedge clk);
    engine_valid = 1; op_type = CONV; op_num = 1;
    data_start_addr = 30'h999; weight_start_addr = 30'h888; result_start_addr = 30'h777;
    @(negedge clk);
    engine_valid = 0;
    for (int k = 0; k < 5; k++) begin
      dma_p2_ob_we = 1; dma_p2_ob_data = 16'h0BAD;
      dma_p3_ob_we = 1; dma_p3_ob_data = 16'h0077;
      @(negedge clk);
    end
    dma_p2_ob_we = 0; dma_p3_ob_we = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    check_zero_outputs("midreset");
    rdy = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (engine_ready) rdy++;
    end
    check("midreset no ready", rdy, 0);
    run_vec(vecs[5], 99);

    $display("== %0d vectors applied, %0d miscompares ==", vecs_n, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/burst_engine.md
BURST_ENGINE -- requirements
Module: burst_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 16, signed sample width.
REQ-002 SHALL have parameter BURST_LEN, default 16, lanes per burst (power of two, 2..64).
REQ-003 SHALL have parameter AVG_SHIFT, default 3, arithmetic right shift applied to the APOOL sum.
REQ-004 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port engine_valid  in  1  command strobe, sampled only in IDLE.
REQ-007 SHALL have port op_type  in  3  1=CONV, 4=MPOOL, 5=APOOL.
REQ-008 SHALL have port op_num  in  8  number of bursts to reduce per command.
REQ-009 SHALL have port data_start_addr  in  30  first data burst address.
REQ-010 SHALL have port weight_start_addr  in  30  first weight burst address.
REQ-011 SHALL have port result_start_addr  in  30  result burst address.
REQ-012 SHALL have port engine_ready  out  1  one-cycle done pulse.
REQ-013 SHALL have port dma_rd_en  out  1  read request for the current burst.
REQ-014 SHALL have port p2_addr  out  30  data read address.
REQ-015 SHALL have port p3_addr  out  30  weight read address.
REQ-016 SHALL have port dma_p2_ob_we  in  1  data beat valid.
REQ-017 SHALL have port dma_p2_ob_data  in  DATA_W  data beat.
REQ-018 SHALL have port dma_p3_ob_we  in  1  weight beat valid.
REQ-019 SHALL have port dma_p3_ob_data  in  DATA_W  weight beat.
REQ-020 SHALL have port dma_wr_en  out  1  result write request.
REQ-021 SHALL have port p0_addr  out  30  result write address, equal to the latched result_start_addr.
REQ-022 SHALL have port dma_p0_ib_re  in  1  DMA pulls one result beat.
REQ-023 SHALL have port dma_p0_ib_data  out  DATA_W  result beat, valid with dma_p0_ib_valid.
REQ-024 SHALL have port dma_p0_ib_valid  out  1  result beat strobe.

Function
REQ-025 SHALL implement states IDLE, DESER, COMPUTE, NEXT, SER, FINISH.
REQ-026 IDLE: on engine_valid, SHALL latch all command inputs, clear every lane accumulator, and go to DESER. If op_num==0 or op_type is unsupported, it SHALL go directly to FINISH without any DMA activity.
REQ-027 DESER: dma_rd_en SHALL be 1.
  - Data beat k (k<BURST_LEN) SHALL be stored in dbuf[k]; beats beyond BURST_LEN SHALL be ignored.
  - Weights SHALL be stored the same way into wbuf, for CONV only.
  - When every required buffer is full, dma_rd_en SHALL drop and the state SHALL go to COMPUTE.
REQ-028 COMPUTE (1 cycle) SHALL update all lanes i in parallel:
  - CONV: acc[i] += dbuf[i]*wbuf[i], full-precision signed, accumulator width 2*DATA_W+8.
  - MPOOL: acc[i] = max(acc[i], dbuf[i]); on the first burst, acc[i] = dbuf[i].
  - APOOL: acc[i] += dbuf[i].
REQ-029 NEXT: SHALL increment the burst counter, advance p2_addr by BURST_LEN (p3_addr too for CONV), and clear the deser counters. Then DESER if the counter is less than op_num, else SER.
REQ-030 SER: dma_wr_en SHALL be 1. Each dma_p0_ib_re SHALL produce dma_p0_ib_data=res[cnt] with dma_p0_ib_valid=1 on the next cycle, then cnt++. dma_p0_ib_valid SHALL otherwise be 0. After BURST_LEN beats, dma_wr_en SHALL drop and the state SHALL go to FINISH.
REQ-031 res[i] SHALL be: CONV acc; MPOOL acc; APOOL acc>>>AVG_SHIFT; each reduced to DATA_W per REQ-036.
REQ-032 FINISH: engine_ready SHALL be 1 for exactly one cycle, then IDLE. engine_valid outside IDLE SHALL be ignored.
REQ-033 Beats arriving while not in DESER SHALL be dropped. Simultaneous data and weight beats SHALL both be accepted.
REQ-034 Address arithmetic SHALL wrap modulo 2^30.

Reset
REQ-035 rst SHALL force IDLE and zero every output, counter, buffer and accumulator on the next edge, including mid-burst. No engine_ready pulse SHALL follow a reset.

Configuration
REQ-036 With macro BURST_ENGINE_SAT_EN defined, reduction to DATA_W SHALL saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. Undefined, it SHALL take the low DATA_W bits (wrap).

Verification
REQ-037 CONV, op_num=2, d=1..16, w=2 both bursts: result lane i = 4*(i+1), p2_addr steps by 16, one engine_ready pulse.
REQ-038 MPOOL, op_num=3, lane data -5,7,3: result 7. APOOL same data, AVG_SHIFT=0: result 5.
REQ-039 CONV 16'h7FFF*16'h7FFF over 2 bursts: result 16'h7FFF with BURST_ENGINE_SAT_EN; low 16 bits of 32'h7FFE0002 (16'h0002) without it.
REQ-040 op_num=0 and op_type=2: engine_ready within 3 cycles, dma_rd_en and dma_wr_en never asserted.
REQ-041 rst asserted after 5 data beats, then a new command: outputs zero after reset, and the new result is unaffected by the stale beats.
